uart_frame_rx: RTL and testbench

Parametrised byte-stream frame receiver sitting behind the UART byte receiver.
- Frame format: HEADER, then LEN_BYTES of length (MSB first), then N payload bytes, then an optional checksum byte, then TRAILER.
- Forwards payload bytes with a last marker.
- Validates length, checksum, trailer and inter-byte timeout, and reports a per-frame done or error pulse.
- Successor to the fixed 0xAA/16-bit-length/0xBB frame handler. Adds configurable delimiters, length width, checksum, timeout and error reporting.

---
 rtl/uart_frame_pkg.sv | 22 ++
 rtl/uart_frame_chk.sv | 37 +++
 rtl/uart_frame_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receiver.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_TRL
    } state_e;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_LEN  = 3'd1;
    localparam logic [2:0] ERR_CHK  = 3'd2;
    localparam logic [2:0] ERR_TRL  = 3'd3;
    localparam logic [2:0] ERR_TO   = 3'd4;

    localparam logic [1:0] CHK_NONE = 2'd0;
    localparam logic [1:0] CHK_XOR  = 2'd1;
    localparam logic [1:0] CHK_SUM  = 2'd2;

endpackage

// File: rtl/uart_frame_chk.sv
// 8-bit frame checksum accumulator (XOR8 or SUM8), cleared at frame start.
module uart_frame_chk
    import uart_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       fold,
    input  logic [1:0] mode,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (fold) begin
            case (mode)
                CHK_XOR: acc_d = acc_q ^ data;
                CHK_SUM: acc_d = acc_q + data;
                default: acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign sum = acc_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Byte-stream frame receiver: HEADER, big-endian length, payload, optional checksum, TRAILER.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  HEADER    = 8'hAA,
    parameter logic [7:0]  TRAILER   = 8'hBB,
    parameter int unsigned LEN_BYTES = 2,
    parameter int unsigned MAX_LEN   = 1024,
    parameter int unsigned CHK_MODE  = 1,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic [8*LEN_BYTES-1:0] frame_len,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [2:0]             err_code,
    output logic                   busy
);

    localparam int unsigned     LW        = 8 * LEN_BYTES;
    localparam int unsigned     TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LW+31:0]  MAX_EXT   = (LW + 32)'(MAX_LEN);
    localparam state_e          ST_AFTER  = (CHK_MODE == 0) ? ST_TRL : ST_CHK;

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [2:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [2:0]      err_code_q, err_code_d;

    logic            chk_clr, chk_fold;
    logic [7:0]      chk_sum;
    logic [LW-1:0]   len_next;
    logic            timeout_hit;

    uart_frame_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .clr  (chk_clr),
        .fold (chk_fold),
        .mode (2'(CHK_MODE)),
        .data (in_data),
        .sum  (chk_sum)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        err_code_d  = err_code_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        chk_clr     = 1'b0;
        chk_fold    = 1'b0;
        len_next    = LW'({len_q, in_data});

        if ((TIMEOUT > 0) && (state_q != ST_IDLE)) begin
            timer_d = in_valid ? '0 : timer_q + 1'b1;
        end else begin
            timer_d = '0;
        end
        // An arriving byte on the expiry cycle takes priority over the timeout.
        timeout_hit = (TIMEOUT > 0) && (state_q != ST_IDLE) && !in_valid &&
                      (32'(timer_q) == TIMEOUT - 1);

        if (timeout_hit) begin
            err_d      = 1'b1;
            err_code_d = ERR_TO;
            state_d    = ST_IDLE;
        end else if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data == HEADER) begin
                        state_d = ST_LEN;
                        chk_clr = 1'b1;
                        idx_d   = '0;
                        len_d   = '0;
                        rem_d   = '0;
                    end
                end
                ST_LEN: begin
                    chk_fold = 1'b1;
                    len_d    = len_next;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == 3'(LEN_BYTES - 1)) begin
                        idx_d = '0;
                        if ((LW + 32)'(len_next) > MAX_EXT) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_LEN;
                            state_d    = ST_IDLE;
                        end else if (len_next == '0) begin
                            state_d = ST_AFTER;
                        end else begin
                            rem_d   = len_next;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    chk_fold    = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_last_d  = (rem_q == LW'(1));
                    if (rem_q != '0) rem_d = rem_q - 1'b1;
                    if (rem_q <= LW'(1)) state_d = ST_AFTER;
                end
                ST_CHK: begin
                    if (in_data == chk_sum) begin
                        state_d = ST_TRL;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHK;
                        state_d    = ST_IDLE;
                    end
                end
                ST_TRL: begin
                    if (in_data == TRAILER) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TRL;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_len  = len_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed self-checking bench for uart_frame_rx (XOR8 checksum, 16-clock timeout).
module tb_uart_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] frame_len;
    logic        frame_done;
    logic        frame_err;
    logic [2:0]  err_code;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    int unsigned n_out, n_done, n_err;
    logic [31:0] data_acc;
    logic [3:0]  last_acc;

    uart_frame_rx #(
        .HEADER    (8'hAA),
        .TRAILER   (8'hBB),
        .LEN_BYTES (2),
        .MAX_LEN   (1024),
        .CHK_MODE  (1),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_len  (frame_len),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) begin
            n_out    = n_out + 1;
            data_acc = {data_acc[23:0], out_data};
            last_acc = {last_acc[2:0], out_last};
        end
        if (frame_done) n_done = n_done + 1;
        if (frame_err)  n_err  = n_err + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        n_out    = 0;
        n_done   = 0;
        n_err    = 0;
        data_acc = '0;
        last_acc = '0;
    endtask

    // Presents one byte for one clock; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_good_frame();
        send(8'hAA); send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
        send(8'h03); send(8'hBB);
    endtask

    initial begin
        int unsigned to_cycles;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        mon_clear();
        idle(3);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_frame_len", 32'(frame_len), 32'd0);
        check_eq("rst_err_code",  32'(err_code),  32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_pulses",    32'({frame_done, frame_err, out_last}), 32'd0);
        rst = 1'b0;
        idle(1);

        // Good frame
        mon_clear();
        send(8'hAA); send(8'h00); send(8'h03); send(8'h11); send(8'h22);
        check_eq("t1_mid_valid", 32'(out_valid), 32'd1);
        check_eq("t1_mid_data",  32'(out_data),  32'h22);
        check_eq("t1_mid_last",  32'(out_last),  32'd0);
        send(8'h33);
        check_eq("t1_last", 32'(out_last), 32'd1);
        send(8'h03); send(8'hBB);
        check_eq("t1_done", 32'(frame_done), 32'd1);
        check_eq("t1_err",  32'(frame_err),  32'd0);
        check_eq("t1_busy", 32'(busy),       32'd0);
        check_eq("t1_len",  32'(frame_len),  32'd3);
        idle(2);
        check_eq("t1_nout",  n_out,          32'd3);
        check_eq("t1_data",  data_acc[23:0], 32'h112233);
        check_eq("t1_lasts", 32'(last_acc[2:0]), 32'b001);
        check_eq("t1_ndone", n_done, 32'd1);

        // Bad checksum, then bad trailer
        mon_clear();
        send(8'hAA); send(8'h00); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h04);
        check_eq("t2_chk_err",  32'(frame_err), 32'd1);
        check_eq("t2_chk_code", 32'(err_code),  32'd2);
        send(8'hBB);
        idle(2);
        check_eq("t2_chk_ndone", n_done, 32'd0);
        check_eq("t2_chk_nerr",  n_err,  32'd1);
        send(8'hAA); send(8'h00); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h03); send(8'hCC);
        check_eq("t2_trl_err",  32'(frame_err), 32'd1);
        check_eq("t2_trl_code", 32'(err_code),  32'd3);
        check_eq("t2_trl_done", 32'(frame_done), 32'd0);

        // Zero-length frame
        mon_clear();
        send(8'hAA); send(8'h00); send(8'h00); send(8'h00); send(8'hBB);
        check_eq("t3_done", 32'(frame_done), 32'd1);
        check_eq("t3_len",  32'(frame_len),  32'd0);
        idle(2);
        check_eq("t3_nout", n_out, 32'd0);

        // Oversize length 0x0401, then ignored bytes
        mon_clear();
        send(8'hAA); send(8'h04); send(8'h01);
        check_eq("t4_err",  32'(frame_err), 32'd1);
        check_eq("t4_code", 32'(err_code),  32'd1);
        send(8'h11); send(8'h22); send(8'hBB);
        idle(2);
        check_eq("t4_busy", 32'(busy),  32'd0);
        check_eq("t4_nerr", n_err,      32'd1);
        check_eq("t4_nout", n_out,      32'd0);
        check_eq("t4_ndone", n_done,    32'd0);

        // Length exactly MAX_LEN is accepted
        send(8'hAA); send(8'h04); send(8'h00);
        check_eq("t4_max_err",  32'(frame_err), 32'd0);
        check_eq("t4_max_busy", 32'(busy),      32'd1);
        check_eq("t4_max_len",  32'(frame_len), 32'h400);
        idle(20);
        check_eq("t4_max_flush", 32'(busy), 32'd0);

        // Timeout 16 clocks after the last byte
        mon_clear();
        send(8'hAA); send(8'h00);
        to_cycles = 0;
        for (int unsigned i = 1; i <= 24; i++) begin
            @(posedge clk);
            #1;
            if (frame_err && to_cycles == 0) to_cycles = i;
        end
        check_eq("t5_to_cycles", to_cycles, 32'd16);
        check_eq("t5_to_code",   32'(err_code), 32'd4);
        check_eq("t5_to_busy",   32'(busy), 32'd0);

        // Byte on clock 16 prevents the timeout
        mon_clear();
        send(8'hAA); send(8'h00);
        repeat (15) @(posedge clk);
        #1;
        send(8'h03);
        check_eq("t5_rescue_err",  32'(frame_err), 32'd0);
        check_eq("t5_rescue_busy", 32'(busy),      32'd1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h03); send(8'hBB);
        idle(2);
        check_eq("t5_rescue_done", n_done, 32'd1);
        check_eq("t5_rescue_nerr", n_err,  32'd0);

        // Garbage before a good frame
        mon_clear();
        send(8'h55); send(8'hBB); send(8'h00);
        check_eq("t6_garbage_busy", 32'(busy), 32'd0);
        send_good_frame();
        idle(2);
        check_eq("t6_ndone", n_done,         32'd1);
        check_eq("t6_data",  data_acc[23:0], 32'h112233);
        check_eq("t6_nerr",  n_err,          32'd0);

        // Reset during payload
        mon_clear();
        send(8'hAA); send(8'h00); send(8'h03); send(8'h11);
        check_eq("t6_pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t6_rst_data",  32'(out_data),  32'd0);
        check_eq("t6_rst_len",   32'(frame_len), 32'd0);
        check_eq("t6_rst_code",  32'(err_code),  32'd0);
        check_eq("t6_rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        idle(3);
        check_eq("t6_rst_nerr", n_err, 32'd0);
        mon_clear();
        send_good_frame();
        idle(2);
        check_eq("t6_post_ndone", n_done, 32'd1);
        check_eq("t6_post_nout",  n_out,  32'd3);
        check_eq("t6_post_data",  data_acc[23:0], 32'h112233);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
